// File: rtl/present_key_sched_if.sv
// Key-load / round-key stream bundle for the PRESENT-80 key schedule.
// The master is the consumer/loader side and the slave is the key-schedule engine.
interface present_key_sched_if;
  logic        key_load;
  logic [79:0] key_in;
  logic        rk_ready;
  logic        rk_valid;
  logic [63:0] rk_out;
  logic [4:0]  rk_round;
  logic        rk_last;
  logic        busy;

  modport master (
    output key_load, key_in, rk_ready,
    input  rk_valid, rk_out, rk_round, rk_last, busy
  );

  modport slave (
    input  key_load, key_in, rk_ready,
    output rk_valid, rk_out, rk_round, rk_last, busy
  );
endinterface

// File: rtl/present_key_sched.sv
// PRESENT-80 key schedule: loads an 80-bit key and streams round keys K1..K32
// over valid/ready. All outputs come straight from state registers.

module mini_sub (
  input  logic [3:0] i_x,
  output logic [3:0] o_y
);
  always_comb begin
    case (i_x)
      4'h0: o_y = 4'hC;  4'h1: o_y = 4'h5;  4'h2: o_y = 4'h6;  4'h3: o_y = 4'hB;
      4'h4: o_y = 4'h9;  4'h5: o_y = 4'h0;  4'h6: o_y = 4'hA;  4'h7: o_y = 4'hD;
      4'h8: o_y = 4'h3;  4'h9: o_y = 4'hE;  4'hA: o_y = 4'hF;  4'hB: o_y = 4'h8;
      4'hC: o_y = 4'h4;  4'hD: o_y = 4'h7;  4'hE: o_y = 4'h1;  default: o_y = 4'h2;
    endcase
  end
endmodule

module present_key_sched #(
  parameter int KEY_W = 80,
  parameter int RK_W  = 64,
  parameter int N_RK  = 32
) (
  input  logic clk,
  input  logic rst_n,
  present_key_sched_if.slave bus
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;
  localparam logic [5:0] LAST   = 6'(N_RK);

  logic [0:0]       r_state;
  logic [KEY_W-1:0] r_key;
  logic [5:0]       r_cnt;
  logic [4:0]       r_round;
  logic             r_last;

  logic [79:0]      w_rot;
  logic [79:0]      w_next;
  logic [3:0]       w_sb;

  // rotate left by 61, substitute top nibble, fold the emitted index into bits 19:15
  assign w_rot  = {r_key[18:0], r_key[79:19]};
  mini_sub u_sbox (.i_x(w_rot[79:76]), .o_y(w_sb));
  assign w_next = {w_sb, w_rot[75:20], w_rot[19:15] ^ r_cnt[4:0], w_rot[14:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_key   <= '0;
      r_cnt   <= 6'd1;
      r_round <= 5'd0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.key_load) begin
            r_key   <= bus.key_in;
            r_cnt   <= 6'd1;
            r_round <= 5'd0;
            r_last  <= 1'b0;
            r_state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (bus.rk_ready) begin
            if (r_cnt == LAST) begin
              r_state <= S_IDLE;
              r_last  <= 1'b0;
            end else begin
              r_key   <= w_next;
              r_cnt   <= r_cnt + 6'd1;
              // rk_round tracks cnt-1 so the 32nd key fits in 5 bits
              r_round <= r_cnt[4:0];
              r_last  <= (r_cnt == LAST - 6'd1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rk_valid = (r_state == S_EMIT);
  assign bus.busy     = (r_state == S_EMIT);
  assign bus.rk_out   = r_key[KEY_W-1 -: RK_W];
  assign bus.rk_round = r_round;
  assign bus.rk_last  = r_last;
endmodule

// File: tb/tb_present_key_sched.sv
// Directed and randomized checks of the PRESENT-80 key schedule against a
// bench-side bit-level model with hand-derived zero-key vectors.
module tb_present_key_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  present_key_sched_if bus();
  present_key_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;
  logic [63:0] sbox_tbl = 64'h21748FE3DA09B65C;  // nibble n holds S(n)

  function automatic logic [79:0] m_upd(input logic [79:0] k, input logic [4:0] i);
    logic [79:0] r;
    logic [3:0]  top;
    for (int j = 0; j < 80; j++) r[(j + 61) % 80] = k[j];
    top = r[79:76];
    r[79:76] = sbox_tbl[4*top +: 4];
    r[19:15] = r[19:15] ^ i;
    return r;
  endfunction

  task automatic load_key(input logic [79:0] k);
    @(negedge clk);
    bus.key_load = 1'b1;
    bus.key_in   = k;
    @(posedge clk);
    #1 bus.key_load = 1'b0;
  endtask

  task automatic test_reset;
    bus.key_load = 1'b0; bus.key_in = '0; bus.rk_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    checks++;
    if (bus.rk_valid !== 1'b0 || bus.busy !== 1'b0 || bus.rk_out !== 64'h0 ||
        bus.rk_round !== 5'd0 || bus.rk_last !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: valid=%b busy=%b out=%h round=%0d last=%b, required all zero",
               bus.rk_valid, bus.busy, bus.rk_out, bus.rk_round, bus.rk_last);
    end
    @(negedge clk) rst_n = 1'b1;
    bus.rk_ready = 1'b1;
    load_key(80'h0123_4567_89AB_CDEF_1357);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rk_valid !== 1'b0 || bus.busy !== 1'b0 || bus.rk_out !== 64'h0 || bus.rk_round !== 5'd0) begin
      failures++;
      $display("FAIL async_reset_mid_emit: valid=%b busy=%b out=%h round=%0d, required 0 0 0 0",
               bus.rk_valid, bus.busy, bus.rk_out, bus.rk_round);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.rk_valid !== 1'b0) begin
        failures++;
        $display("FAIL no_valid_after_reset: valid=%b, required 0", bus.rk_valid);
      end
    end
  endtask

  task automatic test_zero_key;
    logic [63:0] kv [3];
    logic [79:0] m;
    kv[0] = 64'h0000000000000000;
    kv[1] = 64'hC000000000000000;
    kv[2] = 64'h5000180000000001;
    bus.rk_ready = 1'b1;
    load_key(80'h0);
    m = '0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rk_valid !== 1'b1 || bus.rk_out !== m[79:16] || bus.rk_round !== 5'(i) ||
          bus.rk_last !== (i == 31)) begin
        failures++;
        $display("FAIL zero_key_k%0d: valid=%b out=%h round=%0d last=%b, required 1 %h %0d %b",
                 i + 1, bus.rk_valid, bus.rk_out, bus.rk_round, bus.rk_last, m[79:16], i, i == 31);
      end
      if (i < 3) begin
        checks++;
        if (bus.rk_out !== kv[i]) begin
          failures++;
          $display("FAIL zero_key_vector_k%0d: got %h, required %h", i + 1, bus.rk_out, kv[i]);
        end
      end
      if (i < 31) m = m_upd(m, 5'(i + 1));
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.rk_valid !== 1'b0) begin
      failures++;
      $display("FAIL zero_key_end: busy=%b valid=%b, required 0 0", bus.busy, bus.rk_valid);
    end
  endtask

  task automatic test_backpressure;
    bus.rk_ready = 1'b1;
    load_key(80'h0);
    @(negedge clk);
    checks++;
    if (bus.rk_out !== 64'h0 || bus.rk_round !== 5'd0) begin
      failures++;
      $display("FAIL bp_k1: out=%h round=%0d, required 0 0", bus.rk_out, bus.rk_round);
    end
    @(negedge clk);
    checks++;
    if (bus.rk_out !== 64'hC000000000000000 || bus.rk_round !== 5'd1) begin
      failures++;
      $display("FAIL bp_k2: out=%h round=%0d, required c000000000000000 1", bus.rk_out, bus.rk_round);
    end
    bus.rk_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus.rk_valid !== 1'b1 || bus.rk_out !== 64'hC000000000000000 ||
          bus.rk_round !== 5'd1 || bus.rk_last !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold_c%0d: valid=%b out=%h round=%0d last=%b, required 1 c000000000000000 1 0",
                 c, bus.rk_valid, bus.rk_out, bus.rk_round, bus.rk_last);
      end
    end
    bus.rk_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.rk_valid !== 1'b1 || bus.rk_out !== 64'h5000180000000001 || bus.rk_round !== 5'd2) begin
      failures++;
      $display("FAIL bp_k3_after_release: valid=%b out=%h round=%0d, required 1 5000180000000001 2",
               bus.rk_valid, bus.rk_out, bus.rk_round);
    end
    for (int c = 0; c < 40 && bus.busy; c++) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain_timeout: busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_load_ignored;
    logic [79:0] m;
    bus.rk_ready = 1'b1;
    load_key(80'h0);
    m = '0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rk_valid !== 1'b1 || bus.rk_out !== m[79:16] || bus.rk_round !== 5'(i)) begin
        failures++;
        $display("FAIL load_ignored_k%0d: valid=%b out=%h round=%0d, required 1 %h %0d",
                 i + 1, bus.rk_valid, bus.rk_out, bus.rk_round, m[79:16], i);
      end
      bus.key_load = (i == 0 || i == 5);
      bus.key_in   = {80{1'b1}};
      if (i < 31) m = m_upd(m, 5'(i + 1));
    end
    @(negedge clk);
    bus.key_load = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL load_ignored_end: busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [95:0] raw;
    logic [79:0] m;
    int idx;
    int cyc;
    bit rdy;
    @(negedge clk);
    for (int n = 0; n < 1000; n++) begin
      raw = {$urandom, $urandom, $urandom};
      bus.key_in   = raw[79:0];
      bus.key_load = 1'b1;
      @(posedge clk);
      #1 bus.key_load = 1'b0;
      m = raw[79:0];
      idx = 0;
      cyc = 0;
      while (idx < 32 && cyc < 400) begin
        @(negedge clk);
        cyc++;
        checks++;
        if (bus.rk_valid !== 1'b1 || bus.rk_out !== m[79:16] || bus.rk_round !== 5'(idx) ||
            bus.rk_last !== (idx == 31)) begin
          failures++;
          $display("FAIL b2b_key%0d_k%0d: valid=%b out=%h round=%0d last=%b, required 1 %h %0d %b",
                   n, idx + 1, bus.rk_valid, bus.rk_out, bus.rk_round, bus.rk_last, m[79:16], idx, idx == 31);
        end
        rdy = ($urandom_range(0, 3) != 0);
        bus.rk_ready = rdy;
        if (rdy) begin
          if (idx < 31) m = m_upd(m, 5'(idx + 1));
          idx++;
        end
      end
      if (idx < 32) begin
        checks++;
        failures++;
        $display("FAIL b2b_timeout key%0d: transfers=%0d, required 32", n, idx);
        break;
      end
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.rk_valid !== 1'b0) begin
        failures++;
        $display("FAIL b2b_idle key%0d: busy=%b valid=%b, required 0 0", n, bus.busy, bus.rk_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_key();
    test_backpressure();
    test_load_ignored();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
